// File: rtl/gen_senales_pkg.sv
// Shared constants for the RTC bus-timing generator: port ids, command codes
// and the cont_32 phase boundaries of one 32-cycle transaction frame.
package gen_senales_pkg;

    localparam logic [7:0] CMD_PORT_ID = 8'h10;
    localparam logic [7:0] CFG_PORT_ID = 8'h11;
    localparam logic [7:0] ALM_PORT_ID = 8'h01;

    typedef enum logic [1:0] {
        CMD_READ       = 2'b00,
        CMD_WRITE      = 2'b01,
        CMD_STOP       = 2'b10,
        CMD_WRITE_ONCE = 2'b11
    } cmd_e;

    localparam logic [4:0] PH_CS_A_LO    = 5'd2;
    localparam logic [4:0] PH_WR_A_LO    = 5'd4;
    localparam logic [4:0] PH_WR_A_HI    = 5'd10;
    localparam logic [4:0] PH_CS_A_HI    = 5'd12;
    localparam logic [4:0] PH_DATA_BEGIN = 5'd16;
    localparam logic [4:0] PH_CS_D_LO    = 5'd18;
    localparam logic [4:0] PH_STB_D_LO   = 5'd20;
    localparam logic [4:0] PH_STB_D_HI   = 5'd26;
    localparam logic [4:0] PH_CS_D_HI    = 5'd28;
    localparam logic [4:0] PH_LAST       = 5'd31;

    function automatic logic in_range(input logic [4:0] v, input logic [4:0] lo,
                                      input logic [4:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/gen_senales_phase.sv
// Combinational phase decode: maps a frame position and the latched mode to
// the bus strobes that will be registered for that position.
module gen_senales_phase
    import gen_senales_pkg::*;
(
    input  logic       active,
    input  logic [4:0] phase,
    input  logic       wr_mode,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       le,
    output logic       sync,
    output logic       adv
);

    logic data_stb;

    always_comb begin
        cs_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        a_d      = 1'b0;
        le       = 1'b0;
        sync     = 1'b0;
        adv      = 1'b0;
        data_stb = in_range(phase, PH_STB_D_LO, PH_STB_D_HI);
        if (active) begin
            a_d  = (phase >= PH_DATA_BEGIN);
            cs_n = !(in_range(phase, PH_CS_A_LO, PH_CS_A_HI) ||
                     in_range(phase, PH_CS_D_LO, PH_CS_D_HI));
            // address is always written; the data phase strobe depends on mode
            wr_n = !(in_range(phase, PH_WR_A_LO, PH_WR_A_HI) || (wr_mode && data_stb));
            rd_n = !(!wr_mode && data_stb);
            le   = !wr_mode && (phase == PH_STB_D_HI);
            sync = (phase == PH_LAST);
            adv  = (phase == PH_LAST);
        end
    end

endmodule

// File: rtl/gen_senales.sv
// RTC bus-timing generator top: PicoBlaze registers, frame counter and control.
// Optional alarm-control register and act_crono logic under GEN_SENALES_ALARM_EN.
module gen_senales
    import gen_senales_pkg::*;
#(
    parameter logic [7:0] CMD_PORT = CMD_PORT_ID,
    parameter logic [7:0] CFG_PORT = CFG_PORT_ID,
    parameter logic [7:0] ALM_PORT = ALM_PORT_ID
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic [23:0] alarma,
    input  logic        en_01,
    input  logic [7:0]  out_port,
    input  logic [7:0]  port_id,
    output logic        act_crono,
    output logic        enable_cont_16,
    output logic        CS,
    output logic        RD,
    output logic        WR,
    output logic        A_D,
    output logic [4:0]  cont_32,
    output logic        enable_cont_32,
    output logic        LE,
    output logic        sync
);

    cmd_e       cmd;
    logic       crono_en;
    logic       wr_mode;
    logic       boundary;
    logic       start_frame;
    logic       run_nxt;
    logic [4:0] cont_nxt;
    logic       wr_nxt;
    logic       cs_nxt, rd_nxt, wr_n_nxt, a_d_nxt, le_nxt, sync_nxt, adv_nxt;
    logic       unused_bits;

    assign boundary    = !enable_cont_32 || (cont_32 == PH_LAST);
    assign start_frame = boundary && (cmd != CMD_STOP);

    always_comb begin
        run_nxt  = enable_cont_32;
        cont_nxt = cont_32 + 5'd1;
        wr_nxt   = wr_mode;
        if (boundary) begin
            run_nxt  = start_frame;
            cont_nxt = '0;
            if (start_frame) begin
                wr_nxt = (cmd == CMD_WRITE) || (cmd == CMD_WRITE_ONCE);
            end
        end
    end

    // Decoding the next position lets every strobe line up with cont_32.
    gen_senales_phase u_phase (
        .active  (run_nxt),
        .phase   (cont_nxt),
        .wr_mode (wr_nxt),
        .cs_n    (cs_nxt),
        .rd_n    (rd_nxt),
        .wr_n    (wr_n_nxt),
        .a_d     (a_d_nxt),
        .le      (le_nxt),
        .sync    (sync_nxt),
        .adv     (adv_nxt)
    );

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            cmd            <= CMD_STOP;
            crono_en       <= 1'b0;
            wr_mode        <= 1'b0;
            cont_32        <= '0;
            enable_cont_32 <= 1'b0;
            CS             <= 1'b1;
            RD             <= 1'b1;
            WR             <= 1'b1;
            A_D            <= 1'b0;
            LE             <= 1'b0;
            sync           <= 1'b0;
            enable_cont_16 <= 1'b0;
        end else begin
            cont_32        <= cont_nxt;
            enable_cont_32 <= run_nxt;
            wr_mode        <= wr_nxt;
            CS             <= cs_nxt;
            RD             <= rd_nxt;
            WR             <= wr_n_nxt;
            A_D            <= a_d_nxt;
            LE             <= le_nxt;
            sync           <= sync_nxt;
            enable_cont_16 <= adv_nxt;
            // a single write frame parks the command once it has been consumed
            if (start_frame && (cmd == CMD_WRITE_ONCE)) begin
                cmd <= CMD_STOP;
            end
            if (en_01 && (port_id == CMD_PORT)) begin
                cmd <= cmd_e'(out_port[1:0]);
            end
            if (en_01 && (port_id == CFG_PORT)) begin
                crono_en <= out_port[0];
            end
        end
    end

`ifdef GEN_SENALES_ALARM_EN
    logic [1:0] alm;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            alm       <= 2'b00;
            act_crono <= 1'b0;
        end else begin
            act_crono <= crono_en && alm[1] && !alm[0] && (alarma != 24'd0);
            if (en_01 && (port_id == ALM_PORT)) begin
                alm <= out_port[1:0];
            end
        end
    end

    assign unused_bits = ^out_port[7:2];
`else
    assign act_crono   = 1'b0;
    assign unused_bits = ^{out_port[7:2], alarma, crono_en, ALM_PORT};
`endif

endmodule

// File: tb/tb_gen_senales.sv
// Self-checking bench for gen_senales: directed test-plan items plus random
// register traffic, checked every cycle against a frame-level reference model.
module tb_gen_senales;

    logic        reloj = 1'b0;
    logic        resetM = 1'b0;
    logic [23:0] alarma = '0;
    logic        en_01 = 1'b0;
    logic [7:0]  out_port = '0;
    logic [7:0]  port_id = '0;
    logic        act_crono, enable_cont_16, CS, RD, WR, A_D, enable_cont_32, LE, sync;
    logic [4:0]  cont_32;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

`ifdef GEN_SENALES_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    gen_senales dut (
        .reloj          (reloj),
        .resetM         (resetM),
        .alarma         (alarma),
        .en_01          (en_01),
        .out_port       (out_port),
        .port_id        (port_id),
        .act_crono      (act_crono),
        .enable_cont_16 (enable_cont_16),
        .CS             (CS),
        .RD             (RD),
        .WR             (WR),
        .A_D            (A_D),
        .cont_32        (cont_32),
        .enable_cont_32 (enable_cont_32),
        .LE             (LE),
        .sync           (sync)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: current command, frame position and mode of the frame in flight.
    int       m_cmd   = 2;
    bit       m_crono = 1'b0;
    bit [1:0] m_alm   = 2'b00;
    bit       m_run   = 1'b0;
    int       m_pos   = 0;
    bit       m_wr    = 1'b0;
    bit       m_act   = 1'b0;

    always @(posedge reloj or negedge resetM) begin
        bit act_new;
        if (!resetM) begin
            m_cmd = 2; m_crono = 0; m_alm = 0; m_run = 0; m_pos = 0; m_wr = 0; m_act = 0;
        end else begin
            act_new = ALARM_ON && m_crono && (m_alm == 2'b10) && (alarma != 0);
            if (m_run && m_pos < 31) begin
                m_pos = m_pos + 1;
            end else if (m_cmd != 2) begin
                m_run = 1; m_pos = 0;
                m_wr  = (m_cmd == 1) || (m_cmd == 3);
                if (m_cmd == 3) m_cmd = 2;
            end else begin
                m_run = 0; m_pos = 0;
            end
            m_act = act_new;
            if (en_01) begin
                case (port_id)
                    8'h10: m_cmd = int'(out_port[1:0]);
                    8'h11: m_crono = out_port[0];
                    8'h01: if (ALARM_ON) m_alm = out_port[1:0];
                    default: ;
                endcase
            end
        end
    end

    // {CS, RD, WR, A_D, LE, sync, enable_cont_16} for a frame position
    function automatic logic [6:0] exp_bus(input bit run, input int p, input bit wrm);
        bit cs_win, stb_win, addr_wr;
        if (!run) return 7'b1110000;
        cs_win  = (p >= 2 && p <= 12) || (p >= 18 && p <= 28);
        stb_win = (p >= 20 && p <= 26);
        addr_wr = (p >= 4 && p <= 10);
        return {!cs_win, !(!wrm && stb_win), !(addr_wr || (wrm && stb_win)),
                p >= 16, !wrm && (p == 26), p == 31, p == 31};
    endfunction

    always @(negedge reloj) begin
        if (cmp_en) begin
            chk("bus", {CS, RD, WR, A_D, LE, sync, enable_cont_16}, exp_bus(m_run, m_pos, m_wr));
            chk("frame", {enable_cont_32, cont_32}, {m_run, 5'(m_pos)});
            chk("act_crono", act_crono, m_act);
            chk("rd_wr_excl", RD | WR, 1);
            chk("cs_idle", CS | enable_cont_32, 1);
        end
    end

    task automatic wr_port(input logic [7:0] id, input logic [7:0] d);
        en_01 = 1'b1; port_id = id; out_port = d;
        @(negedge reloj);
        en_01 = 1'b0; port_id = '0; out_port = '0;
    endtask

    task automatic wait_cont(input int v, input int budget);
        int n = 0;
        while (cont_32 !== 5'(v)) begin
            @(negedge reloj);
            n++;
            if (n > budget) begin
                chk("wait_timeout", cont_32, v);
                return;
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge reloj);
        chk("rst_hold", {CS, RD, WR, A_D, LE, sync, enable_cont_16, enable_cont_32, cont_32}, 14'b1110_0000_00000);
        resetM = 1'b1;
        @(negedge reloj);
        cmp_en = 1'b1;
        chk("rst_cont", {enable_cont_32, cont_32}, 0);
        chk("rst_bus", {CS, RD, WR, A_D}, 4'b1110);
        chk("rst_pulses", {LE, sync, enable_cont_16, act_crono}, 0);

        // continuous read
        wr_port(8'h10, 8'h00);
        chk("start_latency0", enable_cont_32, 0);
        @(negedge reloj);
        chk("start_latency1", {enable_cont_32, cont_32}, {1'b1, 5'd0});
        wait_cont(7, 40);
        chk("read_addr_wr", {WR, RD}, 2'b01);
        wait_cont(20, 40);
        chk("read_rd20", {RD, WR, CS, A_D}, 4'b0101);
        wait_cont(26, 10);
        chk("read_le26", {LE, RD}, 2'b10);
        wait_cont(31, 10);
        chk("read_sync31", {sync, enable_cont_16}, 2'b11);
        @(negedge reloj);
        chk("read_wrap", {enable_cont_32, cont_32, sync}, {1'b1, 5'd0, 1'b0});

        // switch to write mid-frame
        wait_cont(12, 40);
        wr_port(8'h10, 8'h01);
        wait_cont(22, 40);
        chk("cur_frame_still_read", {RD, WR}, 2'b01);
        wait_cont(0, 40);
        wait_cont(22, 40);
        chk("write_frame22", {RD, WR, LE}, 3'b100);
        wait_cont(26, 10);
        chk("write_no_le", {LE, WR}, 2'b00);

        // single write frame
        wr_port(8'h10, 8'h03);
        n = 0;
        repeat (100) begin
            @(negedge reloj);
            if (sync) n++;
        end
        chk("once_sync_count", n, 2);
        chk("once_idle", {enable_cont_32, cont_32, CS, RD, WR}, {1'b0, 5'd0, 3'b111});

        // alarm
        alarma = 24'h000101;
        wr_port(8'h11, 8'hF1);
        wr_port(8'h01, 8'h02);
        chk("act_latency", act_crono, 0);
        @(negedge reloj);
        chk("act_on", act_crono, ALARM_ON);
        wr_port(8'h01, 8'h03);
        @(negedge reloj);
        chk("act_ack", act_crono, 0);
        wr_port(8'h01, 8'h02);
        @(negedge reloj);
        chk("act_rearm", act_crono, ALARM_ON);
        alarma = '0;
        @(negedge reloj);
        chk("act_alarma0", act_crono, 0);

        // STOP mid-frame, then a write to an unknown port
        wr_port(8'h10, 8'h00);
        wait_cont(10, 80);
        wr_port(8'h10, 8'h02);
        wait_cont(31, 40);
        chk("stop_finishes", sync, 1);
        @(negedge reloj);
        chk("stop_idle", {enable_cont_32, cont_32}, 0);
        wr_port(8'h55, 8'h00);
        repeat (5) @(negedge reloj);
        chk("bad_port_ignored", {enable_cont_32, CS}, 2'b01);

        // reset in the middle of a read frame
        wr_port(8'h10, 8'h00);
        wait_cont(0, 80);
        wait_cont(22, 40);
        chk("pre_rst_rd", RD, 0);
        #2 resetM = 1'b0;
        #1 chk("rst_mid", {CS, RD, WR, LE, cont_32, enable_cont_32}, {4'b1110, 5'd0, 1'b0});
        @(negedge reloj);
        #2 resetM = 1'b1;
        @(negedge reloj);

        // random register traffic
        repeat (2500) begin
            case ($urandom % 16)
                0, 1, 2: begin
                    logic [7:0] id;
                    case ($urandom % 5)
                        0: id = 8'h10;
                        1: id = 8'h10;
                        2: id = 8'h11;
                        3: id = 8'h01;
                        default: id = 8'($urandom);
                    endcase
                    wr_port(id, 8'($urandom));
                end
                3: begin
                    alarma = ($urandom % 3 == 0) ? 24'd0 : 24'($urandom);
                    @(negedge reloj);
                end
                4: begin
                    if ($urandom % 40 == 0) begin
                        #2 resetM = 1'b0;
                        @(negedge reloj);
                        #2 resetM = 1'b1;
                    end
                    @(negedge reloj);
                end
                default: @(negedge reloj);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
